// File: rtl/sva_seq_checker.sv
// Purpose: hardware checker for "a |-> ##[DELAY_MIN:DELAY_MAX] b" (first match, overlapping attempts).
// Latency: succ/fail/overflow/counters/fail_start update one cycle after the sample_en tick.
// Backpressure: none; an attempt that finds no free slot is dropped and flagged on overflow.
module sva_seq_checker #(
  parameter int DELAY_MIN   = 1,
  parameter int DELAY_MAX   = 3,
  parameter int NUM_THREADS = 4,
  parameter int TIMER_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             grst,
  input  logic                             sample_en,
  input  logic                             a,
  input  logic                             b,
  output logic                             succ,
  output logic                             fail,
  output logic                             overflow,
  output logic                             busy,
  output logic [$clog2(NUM_THREADS+1)-1:0] active_cnt,
  output logic [CNT_WIDTH-1:0]             succ_cnt,
  output logic [CNT_WIDTH-1:0]             fail_cnt,
  output logic [TIMER_WIDTH-1:0]           fail_start
);

  localparam int AGE_W = (DELAY_MAX < 1) ? 1 : $clog2(DELAY_MAX + 1);
  localparam int ACT_W = $clog2(NUM_THREADS + 1);
  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int NUM_W = ACT_W + 1;
  localparam int SUM_W = CNT_WIDTH + NUM_W;
  localparam logic [AGE_W-1:0]     MIN_K   = AGE_W'(DELAY_MIN);
  localparam logic [AGE_W-1:0]     MAX_K   = AGE_W'(DELAY_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Registered attempt slots and the tick timer.
  logic [NUM_THREADS-1:0] slot_act;
  logic [AGE_W-1:0]       slot_age   [NUM_THREADS];
  logic [TIMER_WIDTH-1:0] slot_start [NUM_THREADS];
  logic [TIMER_WIDTH-1:0] timer;

  // Per-tick evaluation results.
  logic [AGE_W-1:0]       slot_k [NUM_THREADS];
  logic [NUM_THREADS-1:0] slot_pass;
  logic [NUM_THREADS-1:0] slot_fail;
  logic                   imm_pass;
  logic                   want_alloc;
  logic                   alloc_ok;
  logic [IDX_W-1:0]       alloc_idx;
  logic [NUM_W-1:0]       pass_num;
  logic [NUM_W-1:0]       fail_num;
  logic [TIMER_WIDTH-1:0] fail_pick;
  logic [SUM_W-1:0]       succ_sum;
  logic [SUM_W-1:0]       fail_sum;
  logic [ACT_W-1:0]       act_num;

  // Evaluate every slot at its incremented age; walking from the top index down
  // leaves the lowest-index failing slot and lowest-index free slot as the winners.
  always_comb begin
    imm_pass   = a && b && (DELAY_MIN == 0);
    want_alloc = a && !imm_pass;
    alloc_ok   = 1'b0;
    alloc_idx  = '0;
    slot_pass  = '0;
    slot_fail  = '0;
    pass_num   = NUM_W'(imm_pass);
    fail_num   = '0;
    fail_pick  = '0;
    act_num    = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      slot_k[i]    = slot_age[i] + AGE_W'(1);
      slot_pass[i] = slot_act[i] && b && ((DELAY_MIN == 0) || (slot_k[i] >= MIN_K));
      slot_fail[i] = slot_act[i] && !b && (slot_k[i] == MAX_K);
      pass_num     = pass_num + NUM_W'(slot_pass[i]);
      fail_num     = fail_num + NUM_W'(slot_fail[i]);
      act_num      = act_num + ACT_W'(slot_act[i]);
      if (slot_fail[i]) begin
        fail_pick = slot_start[i];
      end
      // Free-before-tick only: slots released this tick are not candidates.
      if (!slot_act[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
    succ_sum = SUM_W'(succ_cnt) + SUM_W'(pass_num);
    fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_num);
  end

  assign busy       = |slot_act;
  assign active_cnt = act_num;

  // Slot/timer/counter state: reset beats user clear, user clear beats a tick.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      slot_act   <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        slot_age[i]   <= '0;
        slot_start[i] <= '0;
      end
      timer      <= '0;
      succ       <= 1'b0;
      fail       <= 1'b0;
      overflow   <= 1'b0;
      succ_cnt   <= '0;
      fail_cnt   <= '0;
      fail_start <= '0;
    end else if (grst) begin
      slot_act <= '0;
      timer    <= '0;
      succ     <= 1'b0;
      fail     <= 1'b0;
      overflow <= 1'b0;
    end else if (sample_en) begin
      timer <= timer + TIMER_WIDTH'(1);
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (slot_pass[i] || slot_fail[i]) begin
          slot_act[i] <= 1'b0;
        end else if (slot_act[i]) begin
          slot_age[i] <= slot_k[i];
        end
      end
      if (want_alloc && alloc_ok) begin
        slot_act[alloc_idx]   <= 1'b1;
        slot_age[alloc_idx]   <= '0;
        slot_start[alloc_idx] <= timer;
      end
      overflow <= want_alloc && !alloc_ok;
      succ     <= (pass_num != '0);
      fail     <= (fail_num != '0);
      succ_cnt <= (succ_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : succ_sum[CNT_WIDTH-1:0];
      fail_cnt <= (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_WIDTH-1:0];
      if (fail_num != '0) begin
        fail_start <= fail_pick;
      end
    end else begin
      succ     <= 1'b0;
      fail     <= 1'b0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sva_seq_checker.sv
// Purpose: checks two checker configurations against a tick-distance reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: none; the bench drives every cycle unconditionally.
module tb_sva_seq_checker;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic grst = 1'b0;
  logic sample_en = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  logic        d0_succ, d0_fail, d0_ovf, d0_busy;
  logic [2:0]  d0_active;
  logic [15:0] d0_scnt, d0_fcnt;
  logic [7:0]  d0_fs;

  logic        d1_succ, d1_fail, d1_ovf, d1_busy;
  logic [1:0]  d1_active;
  logic [1:0]  d1_scnt, d1_fcnt;
  logic [7:0]  d1_fs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sva_seq_checker dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .grst(grst), .sample_en(sample_en), .a(a), .b(b),
    .succ(d0_succ), .fail(d0_fail), .overflow(d0_ovf), .busy(d0_busy),
    .active_cnt(d0_active), .succ_cnt(d0_scnt), .fail_cnt(d0_fcnt), .fail_start(d0_fs)
  );

  sva_seq_checker #(
    .DELAY_MIN(0), .DELAY_MAX(3), .NUM_THREADS(2), .TIMER_WIDTH(8), .CNT_WIDTH(2)
  ) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .grst(grst), .sample_en(sample_en), .a(a), .b(b),
    .succ(d1_succ), .fail(d1_fail), .overflow(d1_ovf), .busy(d1_busy),
    .active_cnt(d1_active), .succ_cnt(d1_scnt), .fail_cnt(d1_fcnt), .fail_start(d1_fs)
  );

  // Reference model: each attempt remembers the absolute tick it was spawned on;
  // its fate is decided from the tick distance alone.
  int c_min [2] = '{1, 0};
  int c_max [2] = '{3, 3};
  int c_nt  [2] = '{4, 2};
  int c_cw  [2] = '{16, 2};

  int m_spawn  [2][4];
  int m_tstart [2][4];
  int m_timer  [2];
  int m_scnt   [2];
  int m_fcnt   [2];
  int m_fs     [2];
  bit m_succ   [2];
  bit m_fail   [2];
  bit m_ovf    [2];
  int tick_abs = 0;

  function automatic int m_active(input int c);
    int n = 0;
    for (int s = 0; s < c_nt[c]; s++) if (m_spawn[c][s] >= 0) n++;
    return n;
  endfunction

  task automatic model_step(input int c, input bit r, input bit g, input bit e,
                            input bit ia, input bit ib);
    int passes = 0;
    int fails = 0;
    bit fs_done = 1'b0;
    bit found = 1'b0;
    bit was_free [4];
    int cmax = (1 << c_cw[c]) - 1;
    int d;
    if (r) begin
      for (int s = 0; s < 4; s++) begin m_spawn[c][s] = -1; m_tstart[c][s] = 0; end
      m_timer[c] = 0; m_scnt[c] = 0; m_fcnt[c] = 0; m_fs[c] = 0;
      m_succ[c] = 0; m_fail[c] = 0; m_ovf[c] = 0;
    end else if (g) begin
      for (int s = 0; s < 4; s++) m_spawn[c][s] = -1;
      m_timer[c] = 0;
      m_succ[c] = 0; m_fail[c] = 0; m_ovf[c] = 0;
    end else if (e) begin
      for (int s = 0; s < 4; s++) was_free[s] = (s < c_nt[c]) && (m_spawn[c][s] < 0);
      for (int s = 0; s < c_nt[c]; s++) begin
        if (m_spawn[c][s] >= 0) begin
          d = tick_abs - m_spawn[c][s];
          if (ib && d >= c_min[c]) begin
            passes++;
            m_spawn[c][s] = -1;
          end else if (!ib && d == c_max[c]) begin
            fails++;
            if (!fs_done) begin m_fs[c] = m_tstart[c][s]; fs_done = 1'b1; end
            m_spawn[c][s] = -1;
          end
        end
      end
      m_ovf[c] = 1'b0;
      if (ia) begin
        if (c_min[c] == 0 && ib) passes++;
        else begin
          for (int s = 0; s < c_nt[c]; s++) begin
            if (!found && was_free[s]) begin
              m_spawn[c][s] = tick_abs;
              m_tstart[c][s] = m_timer[c];
              found = 1'b1;
            end
          end
          if (!found) m_ovf[c] = 1'b1;
        end
      end
      m_scnt[c] = (m_scnt[c] + passes > cmax) ? cmax : m_scnt[c] + passes;
      m_fcnt[c] = (m_fcnt[c] + fails > cmax) ? cmax : m_fcnt[c] + fails;
      m_timer[c] = (m_timer[c] + 1) % 256;
      m_succ[c] = (passes > 0);
      m_fail[c] = (fails > 0);
    end else begin
      m_succ[c] = 0; m_fail[c] = 0; m_ovf[c] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.succ",       32'(d0_succ),   32'(m_succ[0]));
    chk("d0.fail",       32'(d0_fail),   32'(m_fail[0]));
    chk("d0.overflow",   32'(d0_ovf),    32'(m_ovf[0]));
    chk("d0.busy",       32'(d0_busy),   32'(m_active(0) != 0));
    chk("d0.active_cnt", 32'(d0_active), 32'(m_active(0)));
    chk("d0.succ_cnt",   32'(d0_scnt),   32'(m_scnt[0]));
    chk("d0.fail_cnt",   32'(d0_fcnt),   32'(m_fcnt[0]));
    chk("d0.fail_start", 32'(d0_fs),     32'(m_fs[0]));
    chk("d1.succ",       32'(d1_succ),   32'(m_succ[1]));
    chk("d1.fail",       32'(d1_fail),   32'(m_fail[1]));
    chk("d1.overflow",   32'(d1_ovf),    32'(m_ovf[1]));
    chk("d1.busy",       32'(d1_busy),   32'(m_active(1) != 0));
    chk("d1.active_cnt", 32'(d1_active), 32'(m_active(1)));
    chk("d1.succ_cnt",   32'(d1_scnt),   32'(m_scnt[1]));
    chk("d1.fail_cnt",   32'(d1_fcnt),   32'(m_fcnt[1]));
    chk("d1.fail_start", 32'(d1_fs),     32'(m_fs[1]));
  endtask

  task automatic step(input bit r, input bit g, input bit e, input bit ia, input bit ib);
    @(negedge clk);
    sys_rst = r; grst = g; sample_en = e; a = ia; b = ib;
    model_step(0, r, g, e, ia, ib);
    model_step(1, r, g, e, ia, ib);
    if (!r && !g && e) tick_abs++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("rst.succ_cnt", 32'(d0_scnt), 32'd0);
    chk("rst.busy",     32'(d0_busy), 32'd0);

    // Pass at distance 2.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk("pass_k2.succ",     32'(d0_succ), 32'd1);
    chk("pass_k2.succ_cnt", 32'(d0_scnt), 32'd1);
    chk("pass_k2.busy",     32'(d0_busy), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("hold.succ_pulse", 32'(d0_succ), 32'd0);

    // Timeout fail of an attempt started at timer=5.
    step(0, 1, 0, 0, 0);
    idle(5);
    step(0, 0, 1, 1, 0);
    idle(3);
    chk("timeout.fail",       32'(d0_fail), 32'd1);
    chk("timeout.fail_cnt",   32'(d0_fcnt), 32'd1);
    chk("timeout.fail_start", 32'(d0_fs),   32'd5);

    // Overlapping attempts with b on ticks 1 and 3.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    idle(4);

    // Overflow on the two-slot instance.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("ovf.active_full", 32'(d1_active), 32'd2);
    step(0, 0, 1, 1, 0);
    chk("ovf.pulse",       32'(d1_ovf),    32'd1);
    chk("ovf.active_cnt",  32'(d1_active), 32'd2);
    idle(4);

    // Zero minimum delay: immediate pass, then grst beating a tick.
    step(0, 0, 1, 1, 1);
    chk("min0.succ",   32'(d1_succ),   32'd1);
    chk("min0.active", 32'(d1_active), 32'd0);
    step(0, 1, 1, 1, 0);
    chk("grst.d0_active", 32'(d0_active), 32'd0);
    chk("grst.d1_active", 32'(d1_active), 32'd0);
    step(0, 0, 1, 1, 0);
    idle(3);
    chk("grst.timer_zero", 32'(d0_fs), 32'd0);

    // Mid-attempt reset discards in-flight attempts.
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    idle(4);
    chk("rst_mid.fail_cnt", 32'(d0_fcnt), 32'd0);

    // Saturation on the 2-bit counters.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
    chk("sat.succ_cnt", 32'(d1_scnt), 32'd3);

    // Timer wrap: attempt started after 260 ticks reports start 4.
    step(0, 1, 0, 0, 0);
    idle(260);
    step(0, 0, 1, 1, 0);
    idle(3);
    chk("wrap.fail_start", 32'(d0_fs), 32'd4);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
